// File: rtl/fp_pkg.sv
// Shared floating-point package.
// Holds the operand width, the width of the adder status flags and the bit
// position of each flag inside the {exception, underflow, overflow} vector.
package fp_pkg;

  localparam int FP_W      = 32;
  localparam int FP_FLAG_W = 3;

  // Bit positions inside the adder flag vector
  localparam int FLAG_OVF  = 0;
  localparam int FLAG_UNF  = 1;
  localparam int FLAG_EXC  = 2;

endpackage : fp_pkg

// File: rtl/fp_add_resq_mem.sv
// Result-queue storage for fp_add_resq.
// DEPTH x WIDTH register file with one synchronous write port and one
// asynchronous read port. The data array is not reset; validity is tracked
// by the owner of the queue pointers.
//
// Ports:
//   clk    - clock, write on rising edge
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - read data (combinational from raddr)
module fp_add_resq_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Storage write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule : fp_add_resq_mem

// File: rtl/fp_add_resq.sv
// Credit-managed result queue behind a floating-point adder.
// Upstream issues an add only while credit_ok is high; the credit accounts
// for both adds still in flight and results already queued, so every done
// pulse is guaranteed a slot. Results leave through a registered
// valid/ready head with no fall-through.
//
// Optional feature: define FP_ADD_RESQ_FLAGS_EN to store the three adder
// flags per entry and expose them on out_flags; otherwise in_flags is
// ignored and out_flags does not exist.
//
// Ports:
//   clk        - clock
//   rst        - synchronous active-high reset
//   issue      - upstream start pulse
//   credit_ok  - one more issue fits
//   in_done    - adder done pulse
//   in_res     - adder result
//   in_flags   - {exception, underflow, overflow}
//   out_valid  - queue head valid
//   out_ready  - consumer accepts head
//   out_res    - head result
//   out_flags  - head flags (FP_ADD_RESQ_FLAGS_EN only)
//   count      - queued entries
//   inflight   - issued but not yet done
//   err        - sticky protocol violation
module fp_add_resq
  import fp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue,
  output logic                     credit_ok,
  input  logic                     in_done,
  input  logic [FP_W-1:0]          in_res,
  input  logic [FP_FLAG_W-1:0]     in_flags,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [FP_W-1:0]          out_res,
`ifdef FP_ADD_RESQ_FLAGS_EN
  output logic [FP_FLAG_W-1:0]     out_flags,
`endif
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   inflight,
  output logic                     err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
`ifdef FP_ADD_RESQ_FLAGS_EN
  localparam int ENTRY_W = FP_W + FP_FLAG_W;
`else
  localparam int ENTRY_W = FP_W;
`endif

  logic [CW-1:0]      count_r;
  logic [CW-1:0]      inflight_r;
  logic [AW-1:0]      wr_ptr_r;
  logic [AW-1:0]      rd_ptr_r;
  logic               out_valid_r;
  logic [FP_W-1:0]    out_res_r;
  logic               err_r;

  logic               full_s;
  logic               credit_ok_s;
  logic               pop_s;
  logic               push_s;
  logic               accept_issue_s;
  logic [CW-1:0]      count_nxt_s;
  logic [AW-1:0]      rd_ptr_nxt_s;
  logic [ENTRY_W-1:0] entry_in_s;
  logic [ENTRY_W-1:0] rd_data_s;
  logic [ENTRY_W-1:0] head_nxt_s;

`ifdef FP_ADD_RESQ_FLAGS_EN
  logic [FP_FLAG_W-1:0] out_flags_r;
  assign entry_in_s = {in_res, in_flags};
`else
  logic unused_flags_s;
  assign unused_flags_s = ^in_flags;
  assign entry_in_s     = in_res;
`endif

  // Credit covers queued plus in-flight work; sum is one bit wider so it
  // cannot wrap when both reach DEPTH.
  assign credit_ok_s    = ({1'b0, inflight_r} + {1'b0, count_r}) < (CW+1)'(DEPTH);
  assign full_s         = (count_r == CW'(DEPTH));
  assign pop_s          = out_valid_r && out_ready;
  assign push_s         = in_done && (!full_s || pop_s);
  assign accept_issue_s = issue && credit_ok_s;
  assign rd_ptr_nxt_s   = pop_s ? (rd_ptr_r + AW'(1)) : rd_ptr_r;

  // Next occupancy from push/pop combination
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Next head: when the slot becoming head is being written this cycle
  // (queue empty after any pop), take the incoming entry directly.
  always_comb begin
    head_nxt_s = rd_data_s;
    if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
      head_nxt_s = entry_in_s;
    end else begin
      head_nxt_s = rd_data_s;
    end
  end

  fp_add_resq_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_mem (
    .clk   (clk),
    .we    (push_s),
    .waddr (wr_ptr_r),
    .wdata (entry_in_s),
    .raddr (rd_ptr_nxt_s),
    .rdata (rd_data_s)
  );

  // Queue pointers, occupancy and registered head
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r     <= CW'(0);
      wr_ptr_r    <= AW'(0);
      rd_ptr_r    <= AW'(0);
      out_valid_r <= 1'b0;
      out_res_r   <= FP_W'(0);
`ifdef FP_ADD_RESQ_FLAGS_EN
      out_flags_r <= FP_FLAG_W'(0);
`endif
    end else begin
      count_r     <= count_nxt_s;
      rd_ptr_r    <= rd_ptr_nxt_s;
      out_valid_r <= (count_nxt_s != CW'(0));
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (count_nxt_s != CW'(0)) begin
`ifdef FP_ADD_RESQ_FLAGS_EN
        out_res_r   <= head_nxt_s[ENTRY_W-1 -: FP_W];
        out_flags_r <= head_nxt_s[FP_FLAG_W-1:0];
`else
        out_res_r   <= head_nxt_s;
`endif
      end
    end
  end

  // In-flight tracking; an accepted issue and a done in the same cycle cancel
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_r <= CW'(0);
    end else if (accept_issue_s && in_done) begin
      inflight_r <= inflight_r;
    end else if (accept_issue_s) begin
      inflight_r <= inflight_r + CW'(1);
    end else if (in_done && (inflight_r != CW'(0))) begin
      inflight_r <= inflight_r - CW'(1);
    end
  end

  // Sticky protocol error: issue without credit, or done dropped at full
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if ((issue && !credit_ok_s) || (in_done && full_s && !pop_s)) begin
      err_r <= 1'b1;
    end
  end

  assign credit_ok = credit_ok_s;
  assign out_valid = out_valid_r;
  assign out_res   = out_res_r;
`ifdef FP_ADD_RESQ_FLAGS_EN
  assign out_flags = out_flags_r;
`endif
  assign count     = count_r;
  assign inflight  = inflight_r;
  assign err       = err_r;

endmodule : fp_add_resq

// File: tb/tb_fp_add_resq.sv
// Directed self-checking bench for fp_add_resq (DEPTH = 4).
module tb_fp_add_resq;

  logic        clk;
  logic        rst;
  logic        issue;
  logic        credit_ok;
  logic        in_done;
  logic [31:0] in_res;
  logic [2:0]  in_flags;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
`ifdef FP_ADD_RESQ_FLAGS_EN
  logic [2:0]  out_flags;
`endif
  logic [2:0]  count;
  logic [2:0]  inflight;
  logic        err;

  int n_checks = 0;
  int n_pass   = 0;

  fp_add_resq #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .issue     (issue),
    .credit_ok (credit_ok),
    .in_done   (in_done),
    .in_res    (in_res),
    .in_flags  (in_flags),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
`ifdef FP_ADD_RESQ_FLAGS_EN
    .out_flags (out_flags),
`endif
    .count     (count),
    .inflight  (inflight),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit later
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; issue = 1'b0; in_done = 1'b0; out_ready = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; issue = 1'b0; in_done = 1'b0; in_res = 32'h0; in_flags = 3'b000; out_ready = 1'b0;
    cyc(); cyc();
    n_checks++; if (count !== 3'd0) $display("FAIL reset_count got %0d want 0", count); else n_pass++;
    n_checks++; if (inflight !== 3'd0) $display("FAIL reset_inflight got %0d want 0", inflight); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
    n_checks++; if (out_res !== 32'h0) $display("FAIL reset_out_res got %h want 0", out_res); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err); else n_pass++;
    n_checks++; if (credit_ok !== 1'b1) $display("FAIL reset_credit got %b want 1", credit_ok); else n_pass++;
`ifdef FP_ADD_RESQ_FLAGS_EN
    n_checks++; if (out_flags !== 3'b000) $display("FAIL reset_out_flags got %b want 000", out_flags); else n_pass++;
`endif
    rst = 1'b0;
  endtask

  // issue at t0, done at t4, head at t5, empty again at t6
  task automatic test_single();
    issue = 1'b1;
    cyc();
    issue = 1'b0;
    n_checks++; if (inflight !== 3'd1) $display("FAIL single_inflight got %0d want 1", inflight); else n_pass++;
    cyc(); cyc(); cyc();
    in_done = 1'b1; in_res = 32'h40400000; out_ready = 1'b1;
    cyc();
    in_done = 1'b0;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL single_valid got %b want 1", out_valid); else n_pass++;
    n_checks++; if (out_res !== 32'h40400000) $display("FAIL single_res got %h want 40400000", out_res); else n_pass++;
    n_checks++; if (count !== 3'd1) $display("FAIL single_count got %0d want 1", count); else n_pass++;
    n_checks++; if (inflight !== 3'd0) $display("FAIL single_inflight_done got %0d want 0", inflight); else n_pass++;
    cyc();
    out_ready = 1'b0;
    n_checks++; if (count !== 3'd0) $display("FAIL single_count_t6 got %0d want 0", count); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL single_valid_t6 got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_credit();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue = 1'b1;
      cyc();
    end
    n_checks++; if (inflight !== 3'd4) $display("FAIL credit_inflight got %0d want 4", inflight); else n_pass++;
    n_checks++; if (credit_ok !== 1'b0) $display("FAIL credit_low got %b want 0", credit_ok); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL credit_err_before got %b want 0", err); else n_pass++;
    cyc();
    issue = 1'b0;
    n_checks++; if (err !== 1'b1) $display("FAIL credit_err_after got %b want 1", err); else n_pass++;
    n_checks++; if (inflight !== 3'd4) $display("FAIL credit_inflight_5th got %0d want 4", inflight); else n_pass++;
  endtask

  task automatic test_order();
    logic [31:0] vals [4];
    vals[0] = 32'h3F800000; vals[1] = 32'h40000000; vals[2] = 32'h40400000; vals[3] = 32'h40800000;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_done = 1'b1; in_res = vals[i];
      cyc();
      in_done = 1'b0;
      n_checks++; if (out_res !== vals[0]) $display("FAIL order_head_hold[%0d] got %h want %h", i, out_res, vals[0]); else n_pass++;
    end
    n_checks++; if (count !== 3'd4) $display("FAIL order_count got %0d want 4", count); else n_pass++;
    n_checks++; if (inflight !== 3'd0) $display("FAIL order_inflight got %0d want 0", inflight); else n_pass++;
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      cyc();
      n_checks++; if (out_res !== vals[i]) $display("FAIL order_pop[%0d] got %h want %h", i, out_res, vals[i]); else n_pass++;
    end
    cyc();
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL order_empty_valid got %b want 0", out_valid); else n_pass++;
    n_checks++; if (credit_ok !== 1'b1) $display("FAIL order_credit got %b want 1", credit_ok); else n_pass++;
  endtask

  task automatic test_full_concurrent();
    logic [31:0] vals [4];
    vals[0] = 32'h3F800000; vals[1] = 32'h40000000; vals[2] = 32'h40400000; vals[3] = 32'h40800000;
    do_reset();
    for (int i = 0; i < 4; i++) begin issue = 1'b1; cyc(); end
    issue = 1'b0;
    for (int i = 0; i < 4; i++) begin in_done = 1'b1; in_res = vals[i]; cyc(); end
    in_done = 1'b1; in_res = 32'h40A00000; out_ready = 1'b1;
    cyc();
    in_done = 1'b0; out_ready = 1'b0;
    n_checks++; if (count !== 3'd4) $display("FAIL full_pp_count got %0d want 4", count); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL full_pp_err got %b want 0", err); else n_pass++;
    n_checks++; if (out_res !== 32'h40000000) $display("FAIL full_pp_head got %h want 40000000", out_res); else n_pass++;
    in_done = 1'b1; in_res = 32'hDEADBEEF;
    cyc();
    in_done = 1'b0;
    n_checks++; if (err !== 1'b1) $display("FAIL full_drop_err got %b want 1", err); else n_pass++;
    n_checks++; if (count !== 3'd4) $display("FAIL full_drop_count got %0d want 4", count); else n_pass++;
    out_ready = 1'b1;
    cyc();
    n_checks++; if (out_res !== 32'h40400000) $display("FAIL full_drain0 got %h want 40400000", out_res); else n_pass++;
    cyc();
    n_checks++; if (out_res !== 32'h40800000) $display("FAIL full_drain1 got %h want 40800000", out_res); else n_pass++;
    cyc();
    n_checks++; if (out_res !== 32'h40A00000) $display("FAIL full_drain2 got %h want 40A00000", out_res); else n_pass++;
    cyc();
    out_ready = 1'b0;
    n_checks++; if (count !== 3'd0) $display("FAIL full_drain_count got %0d want 0", count); else n_pass++;
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 4; i++) begin issue = 1'b1; cyc(); end
    issue = 1'b0;
    for (int i = 0; i < 3; i++) begin in_done = 1'b1; in_res = 32'h3F800000 + i; cyc(); end
    in_done = 1'b0;
    n_checks++; if (count !== 3'd3) $display("FAIL mid_pre_count got %0d want 3", count); else n_pass++;
    n_checks++; if (inflight !== 3'd1) $display("FAIL mid_pre_inflight got %0d want 1", inflight); else n_pass++;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n_checks++; if (count !== 3'd0) $display("FAIL mid_count got %0d want 0", count); else n_pass++;
    n_checks++; if (inflight !== 3'd0) $display("FAIL mid_inflight got %0d want 0", inflight); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL mid_valid got %b want 0", out_valid); else n_pass++;
    n_checks++; if (out_res !== 32'h0) $display("FAIL mid_res got %h want 0", out_res); else n_pass++;
    n_checks++; if (credit_ok !== 1'b1) $display("FAIL mid_credit got %b want 1", credit_ok); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL mid_err got %b want 0", err); else n_pass++;
    in_done = 1'b1; in_res = 32'h41000000;
    cyc();
    in_done = 1'b0;
    n_checks++; if (count !== 3'd1) $display("FAIL mid_late_count got %0d want 1", count); else n_pass++;
    n_checks++; if (inflight !== 3'd0) $display("FAIL mid_late_inflight got %0d want 0", inflight); else n_pass++;
    n_checks++; if (out_res !== 32'h41000000) $display("FAIL mid_late_res got %h want 41000000", out_res); else n_pass++;
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
  endtask

  task automatic test_issue_done_same();
    do_reset();
    issue = 1'b1;
    cyc();
    in_done = 1'b1; in_res = 32'h3F000000;
    cyc();
    issue = 1'b0;
    n_checks++; if (inflight !== 3'd1) $display("FAIL same_inflight got %0d want 1", inflight); else n_pass++;
    n_checks++; if (count !== 3'd1) $display("FAIL same_count got %0d want 1", count); else n_pass++;
    in_res = 32'h3E800000;
    cyc();
    in_done = 1'b0;
    n_checks++; if (inflight !== 3'd0) $display("FAIL same_inflight_done got %0d want 0", inflight); else n_pass++;
    n_checks++; if (count !== 3'd2) $display("FAIL same_count2 got %0d want 2", count); else n_pass++;
    out_ready = 1'b1;
    cyc();
    n_checks++; if (out_res !== 32'h3E800000) $display("FAIL same_second got %h want 3E800000", out_res); else n_pass++;
    cyc();
    out_ready = 1'b0;
    n_checks++; if (count !== 3'd0) $display("FAIL same_empty got %0d want 0", count); else n_pass++;
  endtask

`ifdef FP_ADD_RESQ_FLAGS_EN
  task automatic test_flags();
    do_reset();
    in_done = 1'b1; in_res = 32'h7F800000; in_flags = 3'b101;
    cyc();
    in_res = 32'h00000000; in_flags = 3'b010;
    cyc();
    in_done = 1'b0; in_flags = 3'b000;
    n_checks++; if (out_flags !== 3'b101) $display("FAIL flags_head got %b want 101", out_flags); else n_pass++;
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    n_checks++; if (out_flags !== 3'b010) $display("FAIL flags_second got %b want 010", out_flags); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_credit();
    test_order();
    test_full_concurrent();
    test_mid_reset();
    test_issue_done_same();
`ifdef FP_ADD_RESQ_FLAGS_EN
    test_flags();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_fp_add_resq
